// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide DataMemory.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int data_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    wr,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [ADDR_WIDTH+1:0]   addr,
  input  logic [data_WIDTH-1:0]   wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [data_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    we,
  output logic [data_WIDTH-1:0]   dataIn,
  input  logic [data_WIDTH-1:0]   dataOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic                    wr_q;
  logic [1:0]              size_q;
  logic                    sx_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [data_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic [data_WIDTH-1:0]   rdata_q;
  logic [data_WIDTH-1:0]   din_q;

  logic                    bad;
  logic [4:0]              sh;
  logic [7:0]              byte_l;
  logic [15:0]             half_l;
  logic [data_WIDTH-1:0]   load_d;
  logic [data_WIDTH-1:0]   merge_d;

  // Misaligned or reserved-size requests never touch memory
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      size == 2'b11: bad = 1'b1;
      size == 2'b01: bad = addr[0];
      size == 2'b10: bad = (addr[1:0] != 2'b00);
      default:       bad = 1'b0;
    endcase
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    sh     = {addr_q[1:0], 3'b000};
    byte_l = 8'(dataOut >> sh);
    half_l = addr_q[1] ? dataOut[31:16] : dataOut[15:0];
    load_d = dataOut;
    unique case (size_q)
      2'b00:   load_d = {{24{sx_q & byte_l[7]}}, byte_l};
      2'b01:   load_d = {{16{sx_q & half_l[15]}}, half_l};
      default: load_d = dataOut;
    endcase
    if (size_q[0]) begin
      merge_d = addr_q[1] ? {wdata_q[15:0], dataOut[15:0]}
                          : {dataOut[31:16], wdata_q[15:0]};
    end else begin
      merge_d = (dataOut & ~(32'h0000_00FF << sh))
              | ({24'h0, wdata_q[7:0]} << sh);
    end
  end

  // Access sequencer: capture, read, merge/extract, write, complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sx_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      din_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            wr_q    <= wr;
            size_q  <= size;
            sx_q    <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= bad;
            if (bad) begin
              state_q <= S_DONE;
            end else if (wr && size == 2'b10) begin
              din_q   <= wdata;
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          if (wr_q) begin
            din_q   <= merge_d;
            state_q <= S_WR;
          end else begin
            rdata_q <= load_d;
            state_q <= S_DONE;
          end
        end
        S_WR:   state_q <= S_DONE;
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign we      = (state_q == S_WR);
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign dataIn  = din_q;
  assign address = (state_q == S_IDLE) ? '0
                 : addr_q[ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model.
// Latency, lane handling, errors, handshake and mid-op reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  address;
  logic        we;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  logic [31:0] mem [0:1023];
  int          done_cnt = 0;
  int          we_cnt = 0;
  logic [9:0]  last_we_addr = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.data_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .address(address),
    .we(we), .dataIn(dataIn), .dataOut(dataOut)
  );

  always @(posedge clk) begin
    if (we) mem[address] <= dataIn;
    dataOut <= mem[address];
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= address;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic w, input logic [1:0] sz,
                     input logic sx, input logic [11:0] a,
                     input logic [31:0] wd, output int lat,
                     output logic e);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sign_ext = sx;
    addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 99;
    e = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        e = err;
        break;
      end
    end
  endtask

  int   lat;
  logic e;
  int   w0;
  int   d0;

  initial begin
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00;
    sign_ext = 1'b0; addr = '0; wdata = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_dataIn", dataIn, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(1'b1, 2'b10, 1'b0, 12'h00C, 32'h3333_3333, lat, e);
    run(1'b1, 2'b10, 1'b0, 12'h014, 32'h5555_5555, lat, e);

    w0 = we_cnt;
    run(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, lat, e);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_err", 32'(e), 32'd0);
    chk("wst_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk("wst_we_addr", 32'(last_we_addr), 32'd4);
    chk("wst_mem4", mem[4], 32'hDEAD_BEEF);

    run(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, e);
    chk("wld_lat", 32'(lat), 32'd3);
    chk("wld_err", 32'(e), 32'd0);
    chk("wld_rdata", rdata, 32'hDEAD_BEEF);

    run(1'b0, 2'b00, 1'b1, 12'h011, 32'h0, lat, e);
    chk("lb_s_011", rdata, 32'hFFFF_FFBE);
    run(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, lat, e);
    chk("lb_u_013", rdata, 32'h0000_00DE);
    run(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, lat, e);
    chk("lh_s_012", rdata, 32'hFFFF_DEAD);
    run(1'b0, 2'b01, 1'b0, 12'h010, 32'h0, lat, e);
    chk("lh_u_010", rdata, 32'h0000_BEEF);
    chk("lh_lat", 32'(lat), 32'd3);

    run(1'b1, 2'b00, 1'b0, 12'h012, 32'h1234_565A, lat, e);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_mem4", mem[4], 32'hDE5A_BEEF);
    run(1'b1, 2'b01, 1'b0, 12'h010, 32'hABCD_1234, lat, e);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_mem4", mem[4], 32'hDE5A_1234);
    chk("sh_mem3", mem[3], 32'h3333_3333);
    chk("sh_mem5", mem[5], 32'h5555_5555);

    w0 = we_cnt;
    run(1'b0, 2'b01, 1'b0, 12'h011, 32'h0, lat, e);
    chk("err_h_lat", 32'(lat), 32'd1);
    chk("err_h_err", 32'(e), 32'd1);
    run(1'b1, 2'b10, 1'b0, 12'h012, 32'hFFFF_FFFF, lat, e);
    chk("err_w_lat", 32'(lat), 32'd1);
    chk("err_w_err", 32'(e), 32'd1);
    run(1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFF_FFFF, lat, e);
    chk("err_r_lat", 32'(lat), 32'd1);
    chk("err_r_err", 32'(e), 32'd1);
    chk("err_we_cnt", 32'(we_cnt - w0), 32'd0);
    chk("err_mem4", mem[4], 32'hDE5A_1234);
    run(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, e);
    chk("post_err_err", 32'(e), 32'd0);
    chk("post_err_rdata", rdata, 32'hDE5A_1234);

    @(negedge clk);
    d0 = done_cnt; w0 = we_cnt;
    req = 1'b1; wr = 1'b1; size = 2'b10; sign_ext = 1'b0;
    addr = 12'h020; wdata = 32'h0A0B_0C0D;
    repeat (9) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("hs_done_cnt", 32'(done_cnt - d0), 32'd3);
    chk("hs_we_cnt", 32'(we_cnt - w0), 32'd3);
    chk("hs_mem8", mem[8], 32'h0A0B_0C0D);
    chk("hs_mem4", mem[4], 32'hDE5A_1234);

    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; sign_ext = 1'b0;
    addr = 12'h010; wdata = 32'h0000_00FF;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_we", 32'(we), 32'd0);
    chk("mrst_rdata", rdata, 32'h0);
    chk("mrst_address", 32'(address), 32'd0);
    chk("mrst_dataIn", dataIn, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_mem4", mem[4], 32'hDE5A_1234);
    run(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, e);
    chk("mrst_ld_lat", 32'(lat), 32'd3);
    chk("mrst_ld_rdata", rdata, 32'hDE5A_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
